// File: rtl/tx_scheduler_if.sv
// Requester lanes and transmitter handshake of the shared
// serial transmit path.
interface tx_scheduler_if #(
  parameter int NumReq  = 4,
  parameter int DataLen = 8,
  parameter int Parity  = 1
);
  logic [NumReq-1:0]         ReqValid;
  logic [NumReq*DataLen-1:0] ReqData;
  logic [NumReq-1:0]         ReqAck;
  logic                      DataAvilable;
  logic [DataLen+Parity-1:0] DataOutput;
  logic                      DataFetched;

  modport master (
    input  ReqValid, ReqData, DataFetched,
    output ReqAck, DataAvilable, DataOutput
  );

  modport slave (
    output ReqValid, ReqData, DataFetched,
    input  ReqAck, DataAvilable, DataOutput
  );
endinterface

// File: rtl/tx_scheduler.sv
// Round-robin burst scheduler sharing one serial transmitter
// between NumReq byte producers, with optional header and parity.
module tx_scheduler #(
  parameter int NumReq       = 4,
  parameter int DataLen      = 8,
  parameter int Parity       = 1,
  parameter int ParityEven   = 1,
  parameter int HeaderEnable = 1,
  parameter int MaxBurst     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  tx_scheduler_if.master            bus,
  output logic [$clog2(NumReq)-1:0] GrantId,
  output logic                      Busy
);
  localparam int GW = $clog2(NumReq);
  localparam int OW = DataLen + Parity;

  typedef enum logic [2:0] {
    IDLE, HDR, HDR_WAIT, LOAD, DATA_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic [GW-1:0]       winner;
  logic [3:0]          burst_q, burst_d;
  logic                avail_q, avail_d;
  logic [OW-1:0]       out_q, out_d;
  logic [NumReq-1:0]   ack_q, ack_d;
  logic [DataLen-1:0]  lane;
  logic                found;
  logic                req_g;
  int                  idx;

  function automatic logic [OW-1:0] mk_word(
    input logic [DataLen-1:0] d
  );
    logic p;
    p = (ParityEven != 0) ? ^d : ~^d;
    return OW'({p, d});
  endfunction

  // Rotating priority: search starts just after the last grant.
  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= NumReq; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NumReq) idx = idx - NumReq;
      if (!found && bus.ReqValid[GW'(idx)]) begin
        winner = GW'(idx);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    lane = '0;
    for (int i = 0; i < NumReq; i++)
      if (grant_q == GW'(i))
        lane = bus.ReqData[i*DataLen +: DataLen];
  end

  assign req_g = bus.ReqValid[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    avail_d = avail_q;
    out_d   = out_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|bus.ReqValid) begin
          grant_d = winner;
          burst_d = '0;
          state_d = (HeaderEnable != 0) ? HDR : LOAD;
        end
      end
      HDR: begin
        out_d   = mk_word(DataLen'(grant_q));
        avail_d = 1'b1;
        state_d = HDR_WAIT;
      end
      HDR_WAIT: begin
        if (bus.DataFetched) begin
          avail_d = 1'b0;
          if (req_g) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      LOAD: begin
        if (req_g) begin
          out_d          = mk_word(lane);
          avail_d        = 1'b1;
          ack_d[grant_q] = 1'b1;
          burst_d        = burst_q + 4'd1;
          state_d        = DATA_WAIT;
        end else begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      DATA_WAIT: begin
        if (bus.DataFetched) begin
          avail_d = 1'b0;
          if (req_g && burst_q < 4'(MaxBurst)) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NumReq - 1);
      burst_q <= '0;
      avail_q <= 1'b0;
      out_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      avail_q <= avail_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.ReqAck       = ack_q;
  assign bus.DataAvilable = avail_q;
  assign bus.DataOutput   = out_q;
  assign GrantId          = grant_q;
  assign Busy             = (state_q != IDLE);
endmodule

// File: tb/tb_tx_scheduler.sv
// Bench for tx_scheduler: instance 0 has header/even/burst 4,
// instance 1 has no header/odd/burst 1.
module tb_tx_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [2];
  logic [3:0]  rv   [2];
  logic [31:0] rd   [2];
  logic        df   [2];
  wire  [3:0]  ack  [2];
  wire         da   [2];
  wire  [8:0]  dout [2];
  wire  [1:0]  gid  [2];
  wire         busy [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tx_scheduler_if #(
      .NumReq(4), .DataLen(8), .Parity(1)
    ) bus ();
    assign bus.ReqValid    = rv[g];
    assign bus.ReqData     = rd[g];
    assign bus.DataFetched = df[g];
    assign ack[g]          = bus.ReqAck;
    assign da[g]           = bus.DataAvilable;
    assign dout[g]         = bus.DataOutput;
    tx_scheduler #(
      .NumReq(4), .DataLen(8), .Parity(1),
      .ParityEven(g == 0 ? 1 : 0),
      .HeaderEnable(g == 0 ? 1 : 0),
      .MaxBurst(g == 0 ? 4 : 1)
    ) u_dut (
      .clk(clk),
      .rst(rst[g]),
      .bus(bus.master),
      .GrantId(gid[g]),
      .Busy(busy[g])
    );
  end

  typedef struct {
    int         lane;
    logic [7:0] data;
    logic [8:0] word;
  } vec_t;

  vec_t        tbl [6];
  logic [7:0]  q    [2][4][$];
  logic [7:0]  mq   [4][$];
  logic [10:0] cap  [2][$];
  logic [10:0] expq [2][$];
  int          ackcnt [2][4];
  int          mlast  [2];
  int          cnt    [2];
  int          dly    [2];
  int          nvec, nerr;

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0h required %0h (t=%0t)",
               name, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] pack(
    input int g, input logic [7:0] b, input bit even
  );
    logic p;
    p = even ? ^b : ~^b;
    return {g[1:0], p, b};
  endfunction

  function automatic int capat(input int d, input int i);
    return (i < cap[d].size()) ? int'(cap[d][i]) : -1;
  endfunction

  function automatic int qsize(input int d);
    int s = 0;
    for (int l = 0; l < 4; l++) s += q[d][l].size();
    return s;
  endfunction

  task automatic drive(input int d);
    for (int l = 0; l < 4; l++) begin
      rv[d][l] = (q[d][l].size() != 0);
      rd[d][l*8 +: 8] = (q[d][l].size() != 0) ? q[d][l][0] : 8'h00;
    end
  endtask

  task automatic wait_done(input int d, input int maxc);
    int c = 0;
    while ((busy[d] || qsize(d) != 0 || da[d]) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    chk("done_timeout", int'(c < maxc), 1);
  endtask

  // Reference: rotating grant over non-empty queues, header, then
  // up to MaxBurst bytes per grant.
  task automatic run_model(input int d);
    int  w, n, mb;
    bit  hit, even;
    mb   = (d == 0) ? 4 : 1;
    even = (d == 0);
    while (mq[0].size() + mq[1].size() + mq[2].size()
           + mq[3].size() != 0) begin
      w   = mlast[d];
      hit = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        if (!hit && mq[(mlast[d] + k) % 4].size() != 0) begin
          w   = (mlast[d] + k) % 4;
          hit = 1'b1;
        end
      end
      if (d == 0) expq[d].push_back(pack(w, 8'(w), even));
      n = 0;
      while (n < mb && mq[w].size() != 0) begin
        expq[d].push_back(pack(w, mq[w].pop_front(), even));
        n++;
      end
      mlast[d] = w;
    end
  endtask

  task automatic tests();
    int          c, a3, r;
    int          a [4];
    logic [10:0] hb [8];
    logic [7:0]  b;

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_da", da[d], 0);
      chk("rst_ack", ack[d], 0);
      chk("rst_busy", busy[d], 0);
      chk("rst_gid", gid[d], 0);
      chk("rst_dout", dout[d], 0);
    end
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int i = 0; i < 6; i++) begin
      cap[1].delete();
      @(negedge clk);
      q[1][tbl[i].lane].push_back(tbl[i].data);
      drive(1);
      @(negedge clk);
      chk("tbl_da_early", da[1], 0);
      chk("tbl_busy", busy[1], 1);
      @(negedge clk);
      chk("tbl_da", da[1], 1);
      chk("tbl_ack", ack[1], 1 << tbl[i].lane);
      chk("tbl_word", dout[1], tbl[i].word);
      chk("tbl_gid", gid[1], tbl[i].lane);
      wait_done(1, 50);
      chk("tbl_busy_end", busy[1], 0);
      chk("tbl_cap", capat(1, 0), (tbl[i].lane << 9) | tbl[i].word);
    end

    hb = '{11'h301, 11'h301, 11'h302, 11'h203,
           11'h304, 11'h301, 11'h205, 11'h206};
    cap[0].delete();
    @(negedge clk);
    for (int k = 1; k <= 6; k++) q[0][1].push_back(8'(k));
    drive(0);
    wait_done(0, 400);
    chk("hb_len", cap[0].size(), 8);
    for (int i = 0; i < 8; i++) chk("hb_word", capat(0, i), hb[i]);

    cap[1].delete();
    for (int l = 0; l < 4; l++) a[l] = ackcnt[1][l];
    @(negedge clk);
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 2; k++) q[1][l].push_back(8'(l * 16 + k));
    drive(1);
    wait_done(1, 400);
    chk("rr_len", cap[1].size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_grant", capat(1, i) >>> 9, i % 4);
      chk("rr_byte", capat(1, i) & 'hff, (i % 4) * 16 + i / 4);
    end
    for (int l = 0; l < 4; l++) chk("rr_acks", ackcnt[1][l] - a[l], 2);

    cap[0].delete();
    a3 = ackcnt[0][3];
    @(negedge clk);
    q[0][3].push_back(8'h55);
    drive(0);
    c = 0;
    while (!da[0] && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("drop_hdr_offer", da[0], 1);
    q[0][3].delete();
    drive(0);
    wait_done(0, 100);
    chk("drop_len", cap[0].size(), 1);
    chk("drop_hdr", capat(0, 0), 11'h603);
    chk("drop_noack", ackcnt[0][3] - a3, 0);
    cap[0].delete();
    @(negedge clk);
    q[0][3].push_back(8'h13);
    q[0][0].push_back(8'h10);
    q[0][1].push_back(8'h11);
    drive(0);
    wait_done(0, 300);
    chk("drop_next0", capat(0, 0) >>> 9, 0);
    chk("drop_next1", capat(0, 2) >>> 9, 1);
    chk("drop_next3", capat(0, 4) >>> 9, 3);

    @(negedge clk);
    for (int k = 0; k < 4; k++) q[0][2].push_back(8'hC0 + 8'(k));
    drive(0);
    c = 0;
    while (ack[0] == 4'b0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("rst_burst_ack", ack[0], 4'b0100);
    rst[0] = 1'b1;
    for (int l = 0; l < 4; l++) q[0][l].delete();
    drive(0);
    @(negedge clk);
    chk("mid_rst_da", da[0], 0);
    chk("mid_rst_ack", ack[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_gid", gid[0], 0);
    chk("mid_rst_dout", dout[0], 0);
    rst[0] = 1'b0;
    cap[0].delete();
    @(negedge clk);
    for (int l = 0; l < 4; l++) q[0][l].push_back(8'h20 + 8'(l));
    drive(0);
    wait_done(0, 300);
    chk("post_rst_first", capat(0, 0) >>> 9, 0);
    chk("post_rst_second", capat(0, 2) >>> 9, 1);

    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mlast[d] = 3;
      cap[d].delete();
      for (int l = 0; l < 4; l++) q[d][l].delete();
      drive(d);
    end
    for (r = 0; r < 25; r++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        expq[d].delete();
        cap[d].delete();
        for (int l = 0; l < 4; l++) begin
          mq[l].delete();
          c = $urandom_range(0, 5);
          for (int k = 0; k < c; k++) begin
            b = 8'($urandom);
            mq[l].push_back(b);
            q[d][l].push_back(b);
          end
        end
        run_model(d);
        drive(d);
      end
      wait_done(0, 2000);
      wait_done(1, 2000);
      for (int d = 0; d < 2; d++) begin
        chk("rnd_len", cap[d].size(), expq[d].size());
        for (int i = 0; i < expq[d].size(); i++)
          chk("rnd_word", capat(d, i), expq[d][i]);
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d]   = 1'b1;
      rv[d]    = '0;
      rd[d]    = '0;
      df[d]    = 1'b0;
      cnt[d]   = 0;
      dly[d]   = 1;
      mlast[d] = 3;
      for (int l = 0; l < 4; l++) ackcnt[d][l] = 0;
    end
    tbl[0] = '{2, 8'hA5, 9'h1A5};
    tbl[1] = '{0, 8'hFF, 9'h1FF};
    tbl[2] = '{1, 8'h01, 9'h001};
    tbl[3] = '{0, 8'h80, 9'h080};
    tbl[4] = '{2, 8'h7E, 9'h17E};
    tbl[5] = '{3, 8'h00, 9'h100};
    fork
      forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
          if (ack[d] != 4'b0) begin
            chk("ack_lane", ack[d], 1 << gid[d]);
            for (int l = 0; l < 4; l++) begin
              if (ack[d][l]) begin
                ackcnt[d][l]++;
                if (q[d][l].size() != 0) void'(q[d][l].pop_front());
              end
            end
          end
          drive(d);
          if (df[d]) begin
            df[d] = 1'b0;
          end else if (da[d]) begin
            cnt[d]++;
            if (cnt[d] > dly[d]) begin
              df[d] = 1'b1;
              cap[d].push_back({gid[d], dout[d]});
              cnt[d] = 0;
              dly[d] = $urandom_range(0, 3);
            end
          end else begin
            cnt[d] = 0;
          end
        end
      end
      begin
        tests();
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
      end
    join
  end
endmodule
